// File: rtl/branch_ctrl_pkg.sv
// branch_pkg: branch codes, flag bit indices, FSM states and code-decoding helpers for branch_ctrl
package branch_pkg;
  localparam logic [3:0] BAEQ = 4'd1, BANE = 4'd2, BACS = 4'd3, BACC = 4'd4, BAMI = 4'd5, BAPL = 4'd6;
  localparam logic [3:0] BBEQ = 4'd7, BBNE = 4'd8, BBCS = 4'd9, BBCC = 4'd10, BBMI = 4'd11, BBPL = 4'd12;
  localparam int FLAG_Z = 2, FLAG_N = 1, FLAG_C = 0;
  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;
  function automatic logic is_branch(input logic [3:0] c);
    return c >= BAEQ && c <= BBPL;
  endfunction
  function automatic logic uses_b(input logic [3:0] c);
    return c >= BBEQ && c <= BBPL;
  endfunction
endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: decode-stage branch request and PC redirect/flush response bus
interface branch_ctrl_if #(parameter int ADDR_W = 10);
  logic              br_valid;
  logic [3:0]        br_code;
  logic [ADDR_W-1:0] br_target;
  logic              stall;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              flush;
  logic              br_done;
  modport master(output br_valid, br_code, br_target, input stall, pc_load, pc_target, flush, br_done);
  modport slave(input br_valid, br_code, br_target, output stall, pc_load, pc_target, flush, br_done);
endinterface

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational EQ/NE/CS/CC/MI/PL test of a branch code against A or B flags
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] code,
  input  logic [2:0] flags_a,
  input  logic [2:0] flags_b,
  output logic       taken
);
  logic [2:0] f, k;
  logic       b;
  // k is the condition index 0..5 within the accumulator group; bit 0 inverts the test
  assign f = uses_b(code) ? flags_b : flags_a;
  assign k = uses_b(code) ? code[2:0] - 3'd7 : code[2:0] - 3'd1;
  assign b = k[2:1] == 2'd0 ? f[FLAG_Z] : k[2:1] == 2'd1 ? f[FLAG_C] : f[FLAG_N];
  assign taken = is_branch(code) && (b ^ k[0]);
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: flag registers, hazard stall, branch resolution and flush; BRANCH_STATS_EN adds counters
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  branch_ctrl_if.slave bus,
  input  logic       flag_wr_a,
  input  logic       flag_wr_b,
  input  logic [2:0] flag_a_in,
  input  logic [2:0] flag_b_in,
  input  logic       pend_a,
  input  logic       pend_b,
  output logic [2:0] flags_a,
  output logic [2:0] flags_b
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] cnt_taken,
  output logic [15:0] cnt_not_taken,
  output logic [15:0] cnt_stall
`endif
);
  state_t     state, state_d;
  logic [3:0] code_q, code;
  logic [2:0] cnt, cnt_d, eff_a, eff_b;
  logic       legal, hazard, eval, taken, take;
  assign code   = state == WAIT ? code_q : bus.br_code;
  assign legal  = state == WAIT || (state == IDLE && bus.br_valid && is_branch(bus.br_code));
  // a write-back in the same cycle beats the pending flag and is forwarded
  assign hazard = uses_b(code) ? pend_b && !flag_wr_b : pend_a && !flag_wr_a;
  assign eff_a  = flag_wr_a ? flag_a_in : flags_a;
  assign eff_b  = flag_wr_b ? flag_b_in : flags_b;
  assign bus.stall = legal && hazard;
  assign eval   = legal && !hazard;
  assign take   = eval && taken;
  branch_cond_eval u_eval (.code(code), .flags_a(eff_a), .flags_b(eff_b), .taken(taken));
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (take) begin
      state_d = FLUSH;
      cnt_d   = 3'(FLUSH_DEPTH);
    end else if (eval) state_d = IDLE;
    else if (bus.stall) state_d = WAIT;
    else if (state == FLUSH) begin
      cnt_d   = cnt - 3'd1;
      state_d = cnt == 3'd1 ? IDLE : FLUSH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      code_q        <= '0;
      flags_a       <= '0;
      flags_b       <= '0;
      bus.pc_load   <= 1'b0;
      bus.pc_target <= '0;
      bus.flush     <= 1'b0;
      bus.br_done   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      flags_a <= flag_wr_a ? flag_a_in : flags_a;
      flags_b <= flag_wr_b ? flag_b_in : flags_b;
      if (state == IDLE && bus.stall) code_q <= code;
      if (state == IDLE && (bus.stall || take)) bus.pc_target <= bus.br_target;
      bus.pc_load <= take;
      bus.flush   <= state_d == FLUSH;
      bus.br_done <= (eval && !taken) || (state_d == FLUSH && cnt_d == 3'd1);
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_taken     <= '0;
      cnt_not_taken <= '0;
      cnt_stall     <= '0;
    end else begin
      if (take && ~&cnt_taken) cnt_taken <= cnt_taken + 16'd1;
      if (eval && !taken && ~&cnt_not_taken) cnt_not_taken <= cnt_not_taken + 16'd1;
      if (bus.stall && ~&cnt_stall) cnt_stall <= cnt_stall + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: table-driven per-cycle vectors plus a reset-during-flush sequence
module tb_branch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic flag_wr_a, flag_wr_b, pend_a, pend_b;
  logic [2:0] flag_a_in, flag_b_in, flags_a, flags_b;
  int passed = 0, total = 0;
  branch_ctrl_if #(.ADDR_W(10)) bus();
`ifdef BRANCH_STATS_EN
  logic [15:0] c_t, c_n, c_s;
`endif
  branch_ctrl #(.ADDR_W(10), .FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .flag_wr_a(flag_wr_a), .flag_wr_b(flag_wr_b),
    .flag_a_in(flag_a_in), .flag_b_in(flag_b_in),
    .pend_a(pend_a), .pend_b(pend_b),
    .flags_a(flags_a), .flags_b(flags_b)
`ifdef BRANCH_STATS_EN
    , .cnt_taken(c_t), .cnt_not_taken(c_n), .cnt_stall(c_s)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [3:0] code; logic [9:0] tgt;
    logic wa, wb; logic [2:0] fa, fb; logic pa, pb;
    logic e_st, e_pl, e_fl, e_dn; logic [2:0] e_fa, e_fb; logic [9:0] e_tgt;
  } vec_t;
  vec_t vecs[25];
  function automatic vec_t mk(logic v, logic [3:0] code, logic [9:0] tgt, logic wa, logic wb,
                              logic [2:0] fa, logic [2:0] fb, logic pa, logic pb, logic st,
                              logic pl, logic fl, logic dn, logic [2:0] efa, logic [2:0] efb,
                              logic [9:0] etgt);
    vec_t r;
    r.v = v; r.code = code; r.tgt = tgt; r.wa = wa; r.wb = wb; r.fa = fa; r.fb = fb;
    r.pa = pa; r.pb = pb; r.e_st = st; r.e_pl = pl; r.e_fl = fl; r.e_dn = dn;
    r.e_fa = efa; r.e_fb = efb; r.e_tgt = etgt;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic drive(input vec_t x);
    bus.br_valid = x.v; bus.br_code = x.code; bus.br_target = x.tgt;
    flag_wr_a = x.wa; flag_wr_b = x.wb; flag_a_in = x.fa; flag_b_in = x.fb;
    pend_a = x.pa; pend_b = x.pb;
  endtask
  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0);
    vecs[3]  = mk(1, 7, 10'h155, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4, 10'h155);
    vecs[4]  = mk(1, 2, 10'h3C3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 10'h155);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 10'h155);
    vecs[6]  = mk(1, 3, 10'h2AA, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 4, 10'h2AA);
    vecs[7]  = mk(1, 12, 10'h100, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 4, 10'h2AA);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 4, 10'h2AA);
    vecs[9]  = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 4, 10'h2AA);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 10'h2AA);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 10'h2AA);
    vecs[12] = mk(1, 6, 10'h0AB, 1, 0, 2, 0, 1, 0, 0, 0, 0, 1, 2, 4, 10'h2AA);
    vecs[13] = mk(1, 13, 10'h3FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4, 10'h2AA);
    vecs[14] = mk(1, 9, 10'h0CD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2, 4, 10'h2AA);
    vecs[15] = mk(1, 0, 10'h0EE, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 4, 10'h2AA);
    vecs[16] = mk(1, 10, 10'h0F0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2, 4, 10'h0F0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 4, 10'h0F0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 4, 10'h0F0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4, 10'h0F0);
    vecs[20] = mk(1, 8, 10'h111, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2, 4, 10'h111);
    vecs[21] = mk(0, 0, 0, 0, 1, 0, 4, 0, 1, 0, 0, 0, 1, 2, 4, 10'h111);
    vecs[22] = mk(1, 5, 10'h00A, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 4, 10'h00A);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 4, 10'h00A);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4, 10'h00A);
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", bus.stall, 0);
    chk("reset pc_load", bus.pc_load, 0);
    chk("reset pc_target", bus.pc_target, 0);
    chk("reset flush", bus.flush, 0);
    chk("reset br_done", bus.br_done, 0);
    chk("reset flags_a", flags_a, 0);
    chk("reset flags_b", flags_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), bus.stall, vecs[i].e_st);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc_load", i), bus.pc_load, vecs[i].e_pl);
      chk($sformatf("v%0d flush", i), bus.flush, vecs[i].e_fl);
      chk($sformatf("v%0d br_done", i), bus.br_done, vecs[i].e_dn);
      chk($sformatf("v%0d flags_a", i), flags_a, vecs[i].e_fa);
      chk($sformatf("v%0d flags_b", i), flags_b, vecs[i].e_fb);
      chk($sformatf("v%0d pc_target", i), bus.pc_target, vecs[i].e_tgt);
    end
    @(negedge clk);
    drive(mk(1, 5, 10'h077, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("rst seq flush before", bus.flush, 1);
    chk("rst seq pc_load before", bus.pc_load, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst seq flush", bus.flush, 0);
    chk("rst seq pc_load", bus.pc_load, 0);
    chk("rst seq pc_target", bus.pc_target, 0);
    chk("rst seq flags_a", flags_a, 0);
    chk("rst seq flags_b", flags_b, 0);
    @(negedge clk);
    drive(vecs[0]);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-rst br_done %0d", i), bus.br_done, 0);
      chk($sformatf("post-rst flush %0d", i), bus.flush, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution controller for the decode stage of the pipeline. Holds the architectural Z/N/C flag registers for accumulators A and B and evaluates the 12 conditional branch codes against them. It stalls decode while a flag update for the tested accumulator is still in flight, then redirects the PC and squashes the younger instructions when a branch is taken.

## Interface
- `ADDR_W`, 10, width of the branch target / PC.
- `FLUSH_DEPTH`, 2, cycles of flush after a taken branch (legal range 1..7).

- `clk`  in  1  clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `br_valid`  in  1  decode holds a branch instruction.
- `br_code`  in  4  branch code:
  - 1 BAEQ, 2 BANE, 3 BACS, 4 BACC, 5 BAMI, 6 BAPL (test A flags).
  - 7 BBEQ, 8 BBNE, 9 BBCS, 10 BBCC, 11 BBMI, 12 BBPL (test B flags).
  - 0 and 13..15 are not branches.
- `br_target`  in  ADDR_W  branch destination.
- `flag_wr_a`, `flag_wr_b`  in  1  write-back of the A / B flags this cycle.
- `flag_a_in`, `flag_b_in`  in  3  new flags, {Z,N,C}.
- `pend_a`, `pend_b`  in  1  an instruction in EX/MEM will write the A / B flags.
- `stall`  out  1  hold IF/ID (combinational).
- `pc_load`  out  1  load `pc_target` into the PC (registered).
- `pc_target`  out  ADDR_W  captured target (registered).
- `flush`  out  1  squash the younger instructions (registered).
- `br_done`  out  1  one-cycle pulse when a branch retires (registered).
- `flags_a`, `flags_b`  out  3  architectural flag registers.

## Operation
- **Flag registers.** `flags_x` loads `flag_x_in` on `flag_wr_x` in every state.
- **Forwarding.** Effective flags are `flag_x_in` when `flag_wr_x=1`, otherwise `flags_x`.
- **Conditions.** EQ means Z=1, NE Z=0, CS C=1, CC C=0, MI N=1, PL N=0, applied to the selected accumulator.
- **IDLE**
  - A legal `br_valid` with the selected `pend_x=1` and `flag_wr_x=0` asserts `stall`, captures code and target, and goes to WAIT.
  - Otherwise the branch is evaluated this cycle with the effective flags.
    - Taken: capture the target, load the counter with FLUSH_DEPTH, go to FLUSH.
    - Not taken: `br_done=1` next cycle, stay in IDLE.
  - An illegal code is ignored: no outputs change.
- **WAIT**
  - `stall=1` until `flag_wr_x=1` or `pend_x=0`.
  - In that cycle `stall=0` and the captured branch is evaluated as in IDLE, using the captured code.
  - `br_valid` and `br_code` are not re-sampled in WAIT.
- **FLUSH**
  - `flush=1` while the counter is nonzero; the counter decrements each cycle.
  - `br_valid` is ignored.
  - On the last flush cycle `br_done=1`, then the FSM returns to IDLE.
- **Reset values.** All outputs 0, flags 000, state IDLE, counter 0. Reset mid-WAIT or mid-FLUSH abandons the branch and issues no `br_done`.

## Timing
- Branch evaluated in cycle T, not taken: `br_done` at T+1; zero stall cycles.
- Branch evaluated in cycle T, taken:
  - `pc_load=1` at T+1 only.
  - `flush=1` from T+1 to T+FLUSH_DEPTH.
  - `br_done` at T+FLUSH_DEPTH.
  - Earliest next branch accepted at T+FLUSH_DEPTH+1.
- Stall latency:
  - `stall` responds combinationally in the cycle the hazard exists.
  - A branch whose flags arrive k cycles after decode stalls k cycles; the flag value is forwarded the same cycle, with no extra bubble.
- Simultaneous `pend_x=1` and `flag_wr_x=1`: the write wins, so there is no stall and the new flags are used.
- A pending write on the other accumulator never stalls.

## Configuration
- `BRANCH_STATS_EN`, when defined, adds three output ports, all reset to 0:
  - `cnt_taken` (16 b, saturating): increments at each taken resolution.
  - `cnt_not_taken` (16 b, saturating): increments at each not-taken resolution.
  - `cnt_stall` (16 b, saturating): increments on each cycle with `stall=1`.
- Without the macro these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- **Package `branch_pkg`:**
  - Branch code constants: BAEQ=1 .. BBPL=12.
  - Flag bit indices: Z=2, N=1, C=0.
  - FSM state encoding: IDLE, WAIT, FLUSH.
  - Helpers: `is_branch` (code in 1..12) and `uses_b` (code in 7..12).
- **Sub-module `branch_cond_eval`:** combinational; takes code, effective A/B flags and returns `taken`. It is instantiated once and fed the effective flags.

## Test plan
- **Not-taken, no hazard.** `flags_a=000`, `br_valid=1`, `br_code=1` → `br_done=1` at T+1, `pc_load=0`, `flush=0`, `stall=0`.
- **Taken, FLUSH_DEPTH=2.** `flags_b=100`, `br_code=7`, `br_target=0x155` → T+1 `pc_load=1`, `pc_target=0x155`; `flush=1` at T+1..T+2; `br_done` at T+2.
- **Hazard.** `br_code=3`, `pend_a=1` for 3 cycles, then `flag_wr_a=1` with `flag_a_in=001` → `stall=1` for 3 cycles, 0 on the write cycle; taken, `pc_load` the next cycle.
- **Forwarding tie.** `br_code=6`, `pend_a=1`, `flag_wr_a=1`, `flag_a_in=010` in the same cycle → no stall; not taken (N=1).
- **Illegal code and cross-accumulator pending.** `br_code=13` → no response. `br_code=9` with `pend_a=1` only → no stall.
- **Reset mid-FLUSH.** `rst_n=0` during FLUSH → `flush` and `pc_load` drop immediately, flags read 000, no `br_done` afterwards.
